addsub_arbiter: RTL and testbench



---
 rtl/addsub_arbiter.sv | 148 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_arbiter: round-robin arbiter sharing one ripple add/sub datapath.   |
// | Optional OVF output enabled by macro ADDSUB_ARB_OVF_EN.   Revision: 1.0    |
// +----------------------------------------------------------------------------+
module addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             MODE0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             MODE1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             BUSY
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic             OVF
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
`ifdef ADDSUB_ARB_OVF_EN
  logic             ovf_q, ovf_d;
`endif
  logic             pick;

  // Subtract is A + ~B + 1: MODE both inverts B and seeds the carry chain.
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  assign b_x      = b_q ^ {WIDTH{mode_q}};
  assign carry[0] = mode_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign sum[i]     = a_q[i] ^ b_x[i] ^ carry[i];
    assign carry[i+1] = (a_q[i] & b_x[i]) | (carry[i] & (a_q[i] ^ b_x[i]));
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef ADDSUB_ARB_OVF_EN
    ovf_d   = ovf_q;
`endif
    // On a tie the requester that did not win last time is chosen.
    pick    = (REQ0 && REQ1) ? ~last_q : REQ1;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          sel_d   = pick;
          last_d  = pick;
          a_d     = pick ? A1 : A0;
          b_d     = pick ? B1 : B0;
          mode_d  = pick ? MODE1 : MODE0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d     = sum;
        co_d    = carry[WIDTH];
`ifdef ADDSUB_ARB_OVF_EN
        ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
`endif
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef ADDSUB_ARB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign GNT0  = (state_q == EXEC) && !sel_q;
  assign GNT1  = (state_q == EXEC) &&  sel_q;
  assign DONE0 = (state_q == RESP) && !sel_q;
  assign DONE1 = (state_q == RESP) &&  sel_q;
  assign BUSY  = (state_q != IDLE);
  assign S     = s_q;
  assign CO    = co_q;
`ifdef ADDSUB_ARB_OVF_EN
  assign OVF   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_addsub_arbiter: self-checking bench for addsub_arbiter.                 |
// | Checks OVF when ADDSUB_ARB_OVF_EN is defined.             Revision: 1.0    |
// +----------------------------------------------------------------------------+
module tb_addsub_arbiter;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             REQ0, REQ1, MODE0, MODE1;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic             GNT0, GNT1, DONE0, DONE1, CO, BUSY;
  logic [WIDTH-1:0] S;
`ifdef ADDSUB_ARB_OVF_EN
  logic             OVF;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic last_win;

  always #5 CLK = ~CLK;

  addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .A0(A0), .B0(B0), .MODE0(MODE0),
    .REQ1(REQ1), .A1(A1), .B1(B1), .MODE1(MODE1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .S(S), .CO(CO), .BUSY(BUSY)
`ifdef ADDSUB_ARB_OVF_EN
    , .OVF(OVF)
`endif
  );

  task automatic tick;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Reference arithmetic from integer values: returns {ovf, co, s}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic m);
    int ua, ub, sa, sb, r, sr;
    logic co, ovf;
    logic [WIDTH-1:0] s;
    ua = int'(a);
    ub = int'(b);
    sa = a[WIDTH-1] ? ua - (1 << WIDTH) : ua;
    sb = b[WIDTH-1] ? ub - (1 << WIDTH) : ub;
    if (m) begin
      r = ua - ub; co = (ua >= ub); sr = sa - sb;
    end else begin
      r = ua + ub; co = (r >= (1 << WIDTH)); sr = sa + sb;
    end
    s   = WIDTH'((r + (1 << WIDTH)) % (1 << WIDTH));
    ovf = (sr > (1 << (WIDTH-1)) - 1) || (sr < -(1 << (WIDTH-1)));
    return {ovf, co, s};
  endfunction

  function automatic logic [WIDTH+1:0] observed_result();
`ifdef ADDSUB_ARB_OVF_EN
    return {OVF, CO, S};
`else
    return {1'b0, CO, S};
`endif
  endfunction

  function automatic logic [WIDTH+1:0] mask_result(input logic [WIDTH+1:0] e);
`ifdef ADDSUB_ARB_OVF_EN
    return e;
`else
    return {1'b0, e[WIDTH:0]};
`endif
  endfunction

  // One operation issued from IDLE with the given request mask.
  task automatic do_op(input logic [1:0] mask,
                       input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic m0,
                       input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic m1,
                       input string nm);
    logic             who;
    logic [WIDTH+1:0] e;
    logic [4:0]       flags, want;
    who = (mask == 2'b11) ? ~last_win : mask[1];
    e   = who ? model(a1, b1, m1) : model(a0, b0, m0);
    A0 = a0; B0 = b0; MODE0 = m0; REQ0 = mask[0];
    A1 = a1; B1 = b1; MODE1 = m1; REQ1 = mask[1];
    tick;
    tests++;
    flags = {GNT0, GNT1, DONE0, DONE1, BUSY};
    want  = {~who, who, 1'b0, 1'b0, 1'b1};
    if (flags !== want) begin
      fails++;
      $display("FAIL %s grant: gnt0/gnt1/done0/done1/busy=%b expected %b", nm, flags, want);
    end
    A0 = WIDTH'($urandom); B0 = WIDTH'($urandom); MODE0 = 1'($urandom);
    A1 = WIDTH'($urandom); B1 = WIDTH'($urandom); MODE1 = 1'($urandom);
    tick;
    tests++;
    flags = {GNT0, GNT1, DONE0, DONE1, BUSY};
    want  = {1'b0, 1'b0, ~who, who, 1'b1};
    if (flags !== want) begin
      fails++;
      $display("FAIL %s done: gnt0/gnt1/done0/done1/busy=%b expected %b", nm, flags, want);
    end
    tests++;
    if (observed_result() !== mask_result(e)) begin
      fails++;
      $display("FAIL %s result: ovf/co/s=%h expected %h", nm, observed_result(), mask_result(e));
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick;
    tests++;
    flags = {GNT0, GNT1, DONE0, DONE1, BUSY};
    if (flags !== 5'b0 || observed_result() !== mask_result(e)) begin
      fails++;
      $display("FAIL %s idle_hold: flags=%b ovf/co/s=%h expected flags=00000 ovf/co/s=%h",
               nm, flags, observed_result(), mask_result(e));
    end
    last_win = who;
  endtask

  task automatic test_reset;
    logic [4:0] flags;
    RST_N = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1;
    A0 = 8'h12; B0 = 8'h34; MODE0 = 1'b0;
    A1 = 8'h99; B1 = 8'h11; MODE1 = 1'b1;
    tick;
    tick;
    tests++;
    flags = {GNT0, GNT1, DONE0, DONE1, BUSY};
    if (flags !== 5'b0 || observed_result() !== '0) begin
      fails++;
      $display("FAIL reset_state: flags=%b ovf/co/s=%h expected all zero", flags, observed_result());
    end
    RST_N = 1'b1;
    last_win = 1'b1;
    do_op(2'b11, 8'h12, 8'h34, 1'b0, 8'h99, 8'h11, 1'b1, "reset_first_tie");
  endtask

  task automatic test_add;
    do_op(2'b01, 8'h55, 8'h15, 1'b0, 8'h00, 8'h00, 1'b0, "add_req0");
    tests++;
    if ({CO, S} !== 9'h06A) begin
      fails++;
      $display("FAIL add_const: co/s=%h expected 06a", {CO, S});
    end
  endtask

  task automatic test_sub;
    do_op(2'b10, 8'h00, 8'h00, 1'b0, 8'h55, 8'h2E, 1'b1, "sub_req1_a");
    tests++;
    if ({CO, S} !== 9'h127) begin
      fails++;
      $display("FAIL sub_const_a: co/s=%h expected 127", {CO, S});
    end
    do_op(2'b10, 8'h00, 8'h00, 1'b0, 8'h15, 8'h55, 1'b1, "sub_req1_b");
    tests++;
    if ({CO, S} !== 9'h0C0) begin
      fails++;
      $display("FAIL sub_const_b: co/s=%h expected 0c0", {CO, S});
    end
  endtask

  task automatic test_ovf;
    do_op(2'b01, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, "ovf_add");
    do_op(2'b01, 8'h80, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0, "ovf_sub");
  endtask

  task automatic test_back_to_back;
    logic             who;
    logic [WIDTH+1:0] e;
    int               w;
    int               prev_done;
    prev_done = -1;
    A0 = WIDTH'($urandom); B0 = WIDTH'($urandom); MODE0 = 1'($urandom);
    A1 = WIDTH'($urandom); B1 = WIDTH'($urandom); MODE1 = 1'($urandom);
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick;
    for (int k = 0; k < 8; k++) begin
      who = ~last_win;
      w = 0;
      while (!(GNT0 || GNT1) && w < 5) begin
        tick;
        w++;
      end
      tests++;
      if ({GNT0, GNT1} !== {~who, who}) begin
        fails++;
        $display("FAIL b2b_grant%0d: gnt0/gnt1=%b expected %b", k, {GNT0, GNT1}, {~who, who});
      end
      e = who ? model(A1, B1, MODE1) : model(A0, B0, MODE0);
      if (who) begin
        A1 = WIDTH'($urandom); B1 = WIDTH'($urandom); MODE1 = 1'($urandom);
      end else begin
        A0 = WIDTH'($urandom); B0 = WIDTH'($urandom); MODE0 = 1'($urandom);
      end
      last_win = who;
      tick;
      tests++;
      if ({DONE0, DONE1} !== {~who, who} || observed_result() !== mask_result(e)) begin
        fails++;
        $display("FAIL b2b_done%0d: done0/done1=%b ovf/co/s=%h expected %b %h",
                 k, {DONE0, DONE1}, observed_result(), {~who, who}, mask_result(e));
      end
      if (k > 0) begin
        tests++;
        if (cyc - prev_done != 3) begin
          fails++;
          $display("FAIL b2b_spacing%0d: done gap=%0d expected 3", k, cyc - prev_done);
        end
      end
      prev_done = cyc;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick;
    tick;
    tests++;
    if ({GNT0, GNT1, DONE0, DONE1, BUSY} !== 5'b0) begin
      fails++;
      $display("FAIL b2b_quiet: flags=%b expected 00000", {GNT0, GNT1, DONE0, DONE1, BUSY});
    end
  endtask

  task automatic test_reset_abort;
    logic [4:0] flags;
    A0 = 8'hA5; B0 = 8'h3C; MODE0 = 1'b0; REQ0 = 1'b1; REQ1 = 1'b0;
    tick;
    tests++;
    if ({GNT0, BUSY} !== 2'b11) begin
      fails++;
      $display("FAIL abort_gnt: gnt0/busy=%b expected 11", {GNT0, BUSY});
    end
    RST_N = 1'b0; REQ0 = 1'b0;
    tick;
    tests++;
    flags = {GNT0, GNT1, DONE0, DONE1, BUSY};
    if (flags !== 5'b0 || observed_result() !== '0) begin
      fails++;
      $display("FAIL abort_clear: flags=%b ovf/co/s=%h expected all zero", flags, observed_result());
    end
    RST_N = 1'b1;
    last_win = 1'b1;
    tick;
    tick;
    tests++;
    flags = {GNT0, GNT1, DONE0, DONE1, BUSY};
    if (flags !== 5'b0) begin
      fails++;
      $display("FAIL abort_no_done: flags=%b expected 00000", flags);
    end
    do_op(2'b11, 8'h0F, 8'hF1, 1'b0, 8'h20, 8'h30, 1'b1, "after_abort");
  endtask

  task automatic test_random;
    logic [1:0] mask;
    for (int k = 0; k < 24; k++) begin
      mask = 2'($urandom_range(0, 3));
      if (mask == 2'b00) begin
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick;
        tests++;
        if ({GNT0, GNT1, DONE0, DONE1, BUSY} !== 5'b0) begin
          fails++;
          $display("FAIL rand_idle%0d: flags=%b expected 00000", k, {GNT0, GNT1, DONE0, DONE1, BUSY});
        end
      end else begin
        do_op(mask, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
              WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand_op");
      end
    end
  endtask

  initial begin
    RST_N = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; MODE0 = 1'b0; MODE1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    last_win = 1'b1;
    test_reset;
    test_add;
    test_sub;
    test_ovf;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
